// File: rtl/pwm_servo_multi.sv
// Multi-channel hobby-servo PWM generator with debounced inc/dec buttons,
// per-channel targets and a per-frame slew limit on the active pulse width.
module pwm_servo_multi #(
  parameter int N_CH       = 4,
  parameter int PERIOD_CYC = 1000000,
  parameter int MIN_CYC    = 50000,
  parameter int MAX_CYC    = 100000,
  parameter int STEP_CYC   = 5000,
  parameter int SLEW_CYC   = 1000,
  parameter int DEB_CYC    = 500000,
  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int W  = $clog2(PERIOD_CYC + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          pb_inc,
  input  logic          pb_dec,
  input  logic [SW-1:0] ch_sel,
  input  logic          home,
  output logic [N_CH-1:0] pwm_out,
  output logic [W-1:0]  pos,
  output logic          frame_start
);

  localparam int DW       = $clog2(DEB_CYC + 1);
  localparam int SLEW_CAP = (SLEW_CYC > PERIOD_CYC) ? PERIOD_CYC : SLEW_CYC;

  localparam logic [W-1:0]  CENTER   = W'((MIN_CYC + MAX_CYC) / 2);
  localparam logic [W-1:0]  LAST     = W'(PERIOD_CYC - 1);
  localparam logic [W-1:0]  SLEW     = W'(SLEW_CAP);
  localparam logic [W-1:0]  MIN_W    = W'(MIN_CYC);
  localparam logic [W-1:0]  MAX_W    = W'(MAX_CYC);
  localparam logic [W:0]    MAX_X    = (W+1)'(MAX_CYC);
  localparam logic [W:0]    STEP_X   = (W+1)'(STEP_CYC);
  localparam logic [W:0]    FLOOR_X  = (W+1)'(MIN_CYC + STEP_CYC);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  // Bit 0 carries the inc button, bit 1 the dec button.
  logic [1:0]    sync1, sync2, deb, deb_d, press;
  logic [DW-1:0] dcnt [2];

  logic [W-1:0] cnt;
  logic [W-1:0] tgt    [N_CH];
  logic [W-1:0] cur    [N_CH];
  logic [W-1:0] tgt_up [N_CH];
  logic [W-1:0] tgt_dn [N_CH];
  logic [W-1:0] cur_nx [N_CH];

  assign press = deb_d & ~deb;

  // Saturating step arithmetic is done one bit wider so neither end can wrap.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      tgt_up[i] = ({1'b0, tgt[i]} + STEP_X > MAX_X) ? MAX_W : W'({1'b0, tgt[i]} + STEP_X);
      tgt_dn[i] = ({1'b0, tgt[i]} < FLOOR_X) ? MIN_W : W'({1'b0, tgt[i]} - STEP_X);
      if (tgt[i] > cur[i])
        cur_nx[i] = (tgt[i] - cur[i] > SLEW) ? cur[i] + SLEW : tgt[i];
      else
        cur_nx[i] = (cur[i] - tgt[i] > SLEW) ? cur[i] - SLEW : tgt[i];
    end
  end

  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < N_CH; i++)
      if (ch_sel == SW'(i)) pos = cur[i];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1       <= '1;
      sync2       <= '1;
      deb         <= '1;
      deb_d       <= '1;
      dcnt[0]     <= '0;
      dcnt[1]     <= '0;
      cnt         <= '0;
      pwm_out     <= '0;
      frame_start <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        tgt[i] <= CENTER;
        cur[i] <= CENTER;
      end
    end else begin
      sync1 <= {pb_dec, pb_inc};
      sync2 <= sync1;
      deb_d <= deb;
      for (int unsigned b = 0; b < 2; b++) begin
        if (sync2[b] != deb[b]) begin
          if (dcnt[b] == DEB_LAST) begin
            deb[b]  <= sync2[b];
            dcnt[b] <= '0;
          end else begin
            dcnt[b] <= dcnt[b] + 1'b1;
          end
        end else begin
          dcnt[b] <= '0;
        end
      end

      // Out-of-range ch_sel matches no channel, so presses fall through.
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (home)
          tgt[i] <= CENTER;
        else if (ch_sel == SW'(i) && press[0] != press[1])
          tgt[i] <= press[0] ? tgt_up[i] : tgt_dn[i];
      end

      if (enable) begin
        cnt         <= (cnt == LAST) ? '0 : cnt + 1'b1;
        frame_start <= (cnt == '0);
        for (int unsigned i = 0; i < N_CH; i++) begin
          pwm_out[i] <= (cnt < cur[i]);
          if (cnt == LAST) cur[i] <= cur_nx[i];
        end
      end else begin
        cnt         <= '0;
        pwm_out     <= '0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_servo_multi.sv
// Directed bench for pwm_servo_multi with a cycle-level reference model and
// hand-computed literal expectations for widths, targets and control edges.
module tb_pwm_servo_multi;

  localparam int N      = 2;
  localparam int P      = 200;
  localparam int MINC   = 20;
  localparam int MAXC   = 40;
  localparam int STEP   = 5;
  localparam int SLEW   = 2;
  localparam int DEB    = 4;
  localparam int CENTER = 30;

  logic       clk = 1'b0;
  logic       rst, enable, pb_inc, pb_dec, home;
  logic [0:0] ch_sel;
  logic [1:0] pwm_out;
  logic [7:0] pos;
  logic       frame_start;

  pwm_servo_multi #(
    .N_CH(N), .PERIOD_CYC(P), .MIN_CYC(MINC), .MAX_CYC(MAXC),
    .STEP_CYC(STEP), .SLEW_CYC(SLEW), .DEB_CYC(DEB)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pb_inc(pb_inc), .pb_dec(pb_dec),
    .ch_sel(ch_sel), .home(home), .pwm_out(pwm_out), .pos(pos),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: frame position, targets, slewed widths and the
  // button stability rule expressed as run lengths of the synchronized pin.
  int  m_cnt, m_tgt[N], m_cur[N], run[2];
  bit [1:0] m_pwm, sy1, sy2, stab, evp;
  bit  m_fs, started = 0;

  always @(posedge clk) begin : model
    bit [1:0] ev;
    bit [1:0] pin;
    int d;
    pin = {pb_dec, pb_inc};
    if (!rst) begin
      started = 1;
      m_cnt = 0; m_pwm = 0; m_fs = 0;
      for (int i = 0; i < N; i++) begin m_tgt[i] = CENTER; m_cur[i] = CENTER; end
      sy1 = 2'b11; sy2 = 2'b11; stab = 2'b11; evp = 0; run[0] = 0; run[1] = 0;
    end else begin
      if (enable) begin
        for (int i = 0; i < N; i++) m_pwm[i] = (m_cnt < m_cur[i]);
        m_fs = (m_cnt == 0);
        if (m_cnt == P - 1) begin
          for (int i = 0; i < N; i++) begin
            d = m_tgt[i] - m_cur[i];
            if (d > SLEW) d = SLEW;
            if (d < -SLEW) d = -SLEW;
            m_cur[i] = m_cur[i] + d;
          end
          m_cnt = 0;
        end else m_cnt++;
      end else begin
        m_pwm = 0; m_fs = 0; m_cnt = 0;
      end
      ev = evp; evp = 0;
      if (home) begin
        for (int i = 0; i < N; i++) m_tgt[i] = CENTER;
      end else if (int'(ch_sel) < N && ev[0] != ev[1]) begin
        if (ev[0]) m_tgt[ch_sel] = (m_tgt[ch_sel] + STEP > MAXC) ? MAXC : m_tgt[ch_sel] + STEP;
        else       m_tgt[ch_sel] = (m_tgt[ch_sel] - STEP < MINC) ? MINC : m_tgt[ch_sel] - STEP;
      end
      for (int b = 0; b < 2; b++) begin
        if (sy2[b] != stab[b]) begin
          run[b]++;
          if (run[b] == DEB) begin
            stab[b] = sy2[b];
            run[b] = 0;
            if (!stab[b]) evp[b] = 1;
          end
        end else run[b] = 0;
      end
      sy2 = sy1; sy1 = pin;
    end
  end

  always @(negedge clk) begin : compare
    int exp_pos;
    if (started) begin
      exp_pos = (int'(ch_sel) < N) ? m_cur[ch_sel] : 0;
      chk("pwm_out", int'(pwm_out), int'(m_pwm));
      chk("frame_start", int'(frame_start), int'(m_fs));
      chk("pos", int'(pos), exp_pos);
    end
  end

  // Pulse-width and frame-interval monitor on the DUT outputs.
  int run_w[N], last_w[N], cyc = 0, last_fs = 0, fs_gap = 0;
  always @(negedge clk) begin : monitor
    cyc++;
    if (started) begin
      for (int i = 0; i < N; i++) begin
        if (pwm_out[i]) run_w[i]++;
        else if (run_w[i] != 0) begin last_w[i] = run_w[i]; run_w[i] = 0; end
      end
      if (frame_start) begin fs_gap = cyc - last_fs; last_fs = cyc; end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fs();
    bit found;
    found = 0;
    for (int k = 0; k < 2 * P && !found; k++) begin
      @(negedge clk);
      if (frame_start) found = 1;
    end
    if (!found) chk("frame_start_timeout", 0, 1);
    tick(1);
  endtask

  task automatic press(input bit inc, input bit dec);
    pb_inc = ~inc; pb_dec = ~dec;
    tick(10);
    pb_inc = 1'b1; pb_dec = 1'b1;
    tick(10);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin run_w[i] = 0; last_w[i] = 0; end
    rst = 1'b0; enable = 1'b1; pb_inc = 1'b1; pb_dec = 1'b1; home = 1'b0; ch_sel = 1'b0;

    // Reset and nominal centre width.
    tick(5);
    chk("reset_pwm", int'(pwm_out), 0);
    rst = 1'b1;
    wait_fs();
    tick(100);
    chk("w0_center", last_w[0], 30);
    chk("w1_center", last_w[1], 30);
    wait_fs();
    chk("frame_gap", fs_gap, 200);
    chk("pos_center", int'(pos), 30);

    // Channel 1 increment with slew.
    ch_sel = 1'b1;
    press(1, 0);
    chk("tgt1_inc", m_tgt[1], 35);
    wait_fs(); tick(60);
    chk("w1_slew_a", last_w[1], 32);
    chk("w0_hold_a", last_w[0], 30);
    wait_fs(); tick(60);
    chk("w1_slew_b", last_w[1], 34);
    wait_fs(); tick(60);
    chk("w1_slew_c", last_w[1], 35);
    chk("w0_hold_c", last_w[0], 30);
    chk("pos_ch1", int'(pos), 35);

    // Channel 0 saturation at both ends.
    ch_sel = 1'b0;
    press(1, 0); chk("tgt0_inc1", m_tgt[0], 35);
    press(1, 0); chk("tgt0_inc2", m_tgt[0], 40);
    press(1, 0); chk("tgt0_inc3", m_tgt[0], 40);
    press(1, 0); chk("tgt0_inc4", m_tgt[0], 40);
    repeat (7) wait_fs();
    tick(60);
    chk("pos_max", int'(pos), 40);
    chk("w0_max", last_w[0], 40);
    press(0, 1); press(0, 1); press(0, 1); press(0, 1);
    chk("tgt0_dec_to_min", m_tgt[0], 20);
    for (int k = 0; k < 4; k++) begin
      press(0, 1);
      chk("tgt0_dec_sat", m_tgt[0], 20);
    end
    repeat (12) wait_fs();
    tick(60);
    chk("pos_min", int'(pos), 20);
    chk("w0_min", last_w[0], 20);

    // Bounce rejection, then one clean press; then both buttons together.
    repeat (5) begin pb_inc = 1'b0; tick(2); pb_inc = 1'b1; tick(2); end
    pb_inc = 1'b0; tick(10); pb_inc = 1'b1; tick(10);
    chk("tgt0_bounce", m_tgt[0], 25);
    press(1, 1);
    chk("tgt0_both", m_tgt[0], 25);
    chk("tgt1_both", m_tgt[1], 35);
    repeat (4) wait_fs();

    // Enable drop at cnt=10, target edit while idle, restart.
    wait_fs();
    tick(8);
    chk("pwm_before_disable", int'(pwm_out), 3);
    enable = 1'b0;
    tick(1);
    chk("pwm_disabled", int'(pwm_out), 0);
    chk("fs_disabled", int'(frame_start), 0);
    ch_sel = 1'b1;
    press(0, 1);
    chk("tgt1_idle_dec", m_tgt[1], 30);
    chk("pos_idle", int'(pos), 35);
    tick(5);
    enable = 1'b1;
    tick(1);
    chk("fs_restart", int'(frame_start), 1);
    chk("pwm_restart", int'(pwm_out), 3);
    tick(60);
    chk("w0_restart", last_w[0], 25);
    chk("w1_restart", last_w[1], 35);

    // home coincides exactly with the debounced inc event on channel 1.
    pb_inc = 1'b0;
    tick(6);
    home = 1'b1;
    tick(1);
    home = 1'b0;
    tick(3);
    pb_inc = 1'b1;
    tick(10);
    chk("home_tgt0", m_tgt[0], 30);
    chk("home_tgt1", m_tgt[1], 30);
    repeat (2) wait_fs();

    // Reset mid-frame.
    wait_fs();
    tick(10);
    rst = 1'b0;
    tick(3);
    chk("rst_mid_pwm", int'(pwm_out), 0);
    chk("rst_mid_fs", int'(frame_start), 0);
    rst = 1'b1;
    tick(1);
    chk("rst_pos", int'(pos), 30);
    chk("rst_cur0", m_cur[0], 30);
    wait_fs();
    tick(60);
    chk("w0_after_rst", last_w[0], 30);
    chk("w1_after_rst", last_w[1], 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_servo_multi.md
PWM_SERVO_MULTI -- requirements
Module: pwm_servo_multi

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of servo channels, range 1..16.
REQ-002 The block SHALL have parameter PERIOD_CYC, default 1000000: frame length in clk cycles (20 ms at 50 MHz).
REQ-003 The block SHALL have parameter MIN_CYC, default 50000: minimum pulse width in cycles; MIN_CYC <= MAX_CYC < PERIOD_CYC.
REQ-004 The block SHALL have parameter MAX_CYC, default 100000: maximum pulse width in cycles.
REQ-005 The block SHALL have parameter STEP_CYC, default 5000: target change per accepted button press.
REQ-006 The block SHALL have parameter SLEW_CYC, default 1000: maximum change of active width per frame, >= 1.
REQ-007 The block SHALL have parameter DEB_CYC, default 500000: debounce stability window in cycles, >= 2.
REQ-008 The block SHALL have input clk, 1 bit: single system clock; all logic on rising edge.
REQ-009 The block SHALL have input rst, 1 bit: reset, synchronous and active-low.
REQ-010 The block SHALL have input enable, 1 bit: high runs frames; low forces outputs low.
REQ-011 The block SHALL have input pb_inc, 1 bit: raw asynchronous push-button, active-low, increments selected target.
REQ-012 The block SHALL have input pb_dec, 1 bit: raw asynchronous push-button, active-low, decrements selected target.
REQ-013 The block SHALL have input ch_sel, width max(1,clog2(N_CH)): channel addressed by buttons; values >= N_CH make presses ignored.
REQ-014 The block SHALL have input home, 1 bit: synchronous level; high sets every target to CENTER=(MIN_CYC+MAX_CYC)/2 (integer division).
REQ-015 The block SHALL have output pwm_out, width N_CH: registered per-channel servo pulse.
REQ-016 The block SHALL have output pos, width W=clog2(PERIOD_CYC+1): active width of channel ch_sel; 0 when ch_sel >= N_CH.
REQ-017 The block SHALL have output frame_start, 1 bit: one-cycle pulse in the first cycle of each frame.

Function
REQ-018 Each button SHALL pass through a two-flop synchronizer, with both flops reset to 1.
REQ-019 The debounced level SHALL change only after the synchronized level has differed from it for DEB_CYC consecutive cycles; any reversion restarts the count.
REQ-020 A press event SHALL be a debounced 1->0 transition, one cycle wide; the release edge generates no event.
REQ-021 On an inc event with ch_sel < N_CH, tgt[ch_sel] SHALL become min(tgt+STEP_CYC, MAX_CYC) on the next clk.
REQ-022 On a dec event with ch_sel < N_CH, tgt[ch_sel] SHALL become max(tgt-STEP_CYC, MIN_CYC) on the next clk; intermediate arithmetic is W+1 bits, with no wrap.
REQ-023 Simultaneous inc and dec events in the same cycle SHALL leave targets unchanged.
REQ-024 home SHALL take priority over button events in the same cycle.
REQ-025 Frame counter cnt SHALL count 0..PERIOD_CYC-1 while enable=1 and wrap to 0.
REQ-026 When cnt==PERIOD_CYC-1, each cur[i] SHALL move toward tgt[i] by min(|tgt-cur|, SLEW_CYC); cur is otherwise constant, so widths change only at frame boundaries (glitch-free).
REQ-027 In the cycle after cnt holds value c with enable=1, pwm_out[i] SHALL equal (c < cur[i]), and frame_start SHALL equal (c==0).
REQ-028 Each channel SHALL therefore be high for exactly cur[i] consecutive cycles per frame, with all channels rising together.
REQ-029 While enable=0, cnt SHALL be held at 0 and pwm_out and frame_start SHALL be 0 from the next cycle.
REQ-030 While enable=0, targets and cur SHALL be retained and button and home events SHALL still update targets.
REQ-031 When enable rises, the first frame SHALL start with cnt=0 in that cycle, and frame_start SHALL pulse on the following cycle.

Reset
REQ-032 When rst=0 at a clk edge, the block SHALL set cnt=0, tgt[i]=cur[i]=CENTER, pwm_out=0, frame_start=0, synchronizers and debounced levels to 1, and debounce counters to 0.
REQ-033 A reset asserted mid-frame or mid-debounce SHALL abort the frame or debounce; no press event SHALL be generated on the release of reset.

Verification (N_CH=2, PERIOD_CYC=200, MIN_CYC=20, MAX_CYC=40, STEP_CYC=5, SLEW_CYC=2, DEB_CYC=4; CENTER=30)
REQ-034 The bench SHALL check: rst=0 for 5 cycles, then release with enable=1 -> pwm_out=00 during reset; each channel high 30 cycles per 200-cycle frame; frame_start every 200 cycles; pos=30.
REQ-035 The bench SHALL check: ch_sel=1, pb_inc low for 10 cycles -> tgt[1]=35; channel 1 width 32, 34, 35 in the next three frames; channel 0 stays 30.
REQ-036 The bench SHALL check: ch_sel=0, four separated pb_inc presses -> tgt[0] 35, 40, 40, 40 (saturation); four pb_dec presses from 20 -> stays 20.
REQ-037 The bench SHALL check: pb_inc toggling every 2 cycles for 20 cycles, then held low 10 cycles -> exactly one increment; pb_inc and pb_dec driven identically -> no target change.
REQ-038 The bench SHALL check: enable=0 at cnt=10 -> pwm_out=00 and cnt=0 next cycle; enable=1 -> frame_start pulses the following cycle with full-width pulses.
REQ-039 The bench SHALL check: home=1 with a simultaneous inc event -> targets=30; rst=0 mid-frame -> outputs 0 and cur=30 after release.
